// File: rtl/reg_writeback_queue.sv
// Register-file write-port arbiter: ALU results take priority, slow results queue in a small FIFO.
// Optional forwarding tap from the output stage is enabled by defining WB_FWD_EN.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          slow_valid,
    output logic          slow_ready,
    input  logic [4:0]    slow_rd,
    input  logic [31:0]   slow_data,
    output logic          wb_we,
    output logic [4:0]    wb_rw,
    output logic [31:0]   wb_busw,
    output logic          busy,
    output logic [AW:0]   count
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]    fwd_ra,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data
`endif
);

    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      cnt;

    logic alu_req;
    logic slow_req;
    logic pop;
    logic bypass;
    logic push;

    assign slow_ready = !rst && (cnt < (AW+1)'(DEPTH));
    assign busy       = (cnt != '0);
    assign count      = cnt;

    always_comb begin
        alu_req  = alu_valid && (alu_rd != 5'd0);
        slow_req = slow_valid && slow_ready && (slow_rd != 5'd0);
        pop      = !alu_req && (cnt != '0);
        bypass   = !alu_req && (cnt == '0) && slow_req;
        push     = slow_req && !bypass;
    end

    // Payload storage needs no reset; occupancy is tracked by cnt and q_vld.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_rd[tail]   <= slow_rd;
            q_data[tail] <= slow_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_rw   <= '0;
            wb_busw <= '0;
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            q_vld   <= '0;
        end else begin
            wb_we <= 1'b0;
            if (alu_req) begin
                wb_we   <= 1'b1;
                wb_rw   <= alu_rd;
                wb_busw <= alu_data;
            end else if (pop) begin
                wb_we <= q_vld[head];
                if (q_vld[head]) begin
                    wb_rw   <= q_rd[head];
                    wb_busw <= q_data[head];
                end
            end else if (bypass) begin
                wb_we   <= 1'b1;
                wb_rw   <= slow_rd;
                wb_busw <= slow_data;
            end

            // Kill older queued writes to the same rd; the tail push below overrides,
            // so an entry pushed this cycle survives.
            if (alu_req) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (q_rd[i] == alu_rd)
                        q_vld[i] <= 1'b0;
                end
            end
            if (push) begin
                q_vld[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;

            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_hit  = wb_we && (wb_rw == fwd_ra) && (fwd_ra != 5'd0);
    assign fwd_data = wb_busw;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: a queue-based reference model predicts each write and its edge,
// a separate monitor pops and compares every DUT output cycle.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        slow_valid;
    logic        slow_ready;
    logic [4:0]  slow_rd;
    logic [31:0] slow_data;
    logic        wb_we;
    logic [4:0]  wb_rw;
    logic [31:0] wb_busw;
    logic        busy;
    logic [AW:0] count;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_ra;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .slow_valid(slow_valid), .slow_ready(slow_ready),
        .slow_rd(slow_rd), .slow_data(slow_data),
        .wb_we(wb_we), .wb_rw(wb_rw), .wb_busw(wb_busw),
        .busy(busy), .count(count)
`ifdef WB_FWD_EN
        , .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct { logic [4:0] rd; logic [31:0] data; bit v; } ent_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int unsigned cyc; } wr_t;

    ent_t mq[$];
    wr_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model to the upcoming edge.
    task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit sv, input logic [4:0] srd, input logic [31:0] sd);
        bit   ready;
        bit   sreq;
        ent_t e;
        wr_t  w;
        @(negedge clk);
        check("count", 32'(count), 32'(mq.size()));
        check("busy", 32'(busy), 32'(mq.size() != 0));
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        slow_valid = sv; slow_rd = srd; slow_data = sd;
        #1;
        ready = !r && (mq.size() < DEPTH);
        check("slow_ready", 32'(slow_ready), 32'(ready));
        if (r) begin
            mq.delete();
        end else begin
            sreq = sv && ready && (srd != 5'd0);
            if (av && ard != 5'd0) begin
                w = '{rd: ard, data: ad, cyc: edge_n + 1};
                exp_q.push_back(w);
                foreach (mq[i]) if (mq[i].rd == ard) mq[i].v = 1'b0;
                if (sreq) mq.push_back('{rd: srd, data: sd, v: 1'b1});
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.v) exp_q.push_back('{rd: e.rd, data: e.data, cyc: edge_n + 1});
                if (sreq) mq.push_back('{rd: srd, data: sd, v: 1'b1});
            end else if (sreq) begin
                exp_q.push_back('{rd: srd, data: sd, cyc: edge_n + 1});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Monitor: compares every output cycle against the scoreboard.
    logic [4:0]  last_rw   = '0;
    logic [31:0] last_busw = '0;
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("rst_we", 32'(wb_we), 32'd0);
                check("rst_rw", 32'(wb_rw), 32'd0);
                check("rst_busw", wb_busw, 32'd0);
                last_rw = '0;
                last_busw = '0;
            end else if (wb_we) begin
                check("we_rw_nonzero", 32'(wb_rw != 5'd0), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got rw=%0d busw=%0h expected no write at edge %0d",
                             wb_rw, wb_busw, edge_n);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_edge", edge_n, w.cyc);
                    check("wr_rw", 32'(wb_rw), 32'(w.rd));
                    check("wr_busw", wb_busw, w.data);
                    last_rw = w.rd;
                    last_busw = w.data;
                end
            end else begin
                if (exp_q.size() != 0 && exp_q[0].cyc <= edge_n) begin
                    checks++;
                    failures++;
                    $display("FAIL missed_write: got wb_we=0 expected rw=%0d busw=%0h at edge %0d",
                             exp_q[0].rd, exp_q[0].data, edge_n);
                    void'(exp_q.pop_front());
                end
                check("hold_rw", 32'(wb_rw), 32'(last_rw));
                check("hold_busw", wb_busw, last_busw);
            end
        end
    end

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        slow_valid = 1'b0; slow_rd = '0; slow_data = '0;
`ifdef WB_FWD_EN
        fwd_ra = '0;
`endif
        // Reset with a slow offer pending: nothing accepted.
        for (int i = 0; i < 3; i++) step(1, 0, 5'd0, 32'd0, 1, 5'd9, 32'hDEAD);
        idle(2);

        // Single ALU write, then an ALU write to r0.
        step(0, 1, 5'd5, 32'h11, 0, 5'd0, 32'd0);
        step(0, 1, 5'd0, 32'h99, 0, 5'd0, 32'd0);
        idle(2);

        // ALU busy every cycle while slow results fill the FIFO; extra offers are refused.
        for (int k = 0; k < 6; k++)
            step(0, 1, 5'(k + 1), 32'h100 + 32'(k), 1, (k < 4) ? 5'(8 + k) : 5'd12, 32'h200 + 32'(k));
        idle(6);

        // WAW kill: queued rd=7 is superseded by a younger ALU write.
        step(0, 1, 5'd1, 32'h1, 1, 5'd7, 32'hAA);
        step(0, 1, 5'd7, 32'hBB, 0, 5'd0, 32'd0);
        idle(3);

        // Bypass: empty FIFO, no ALU.
        step(0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h55);
`ifdef WB_FWD_EN
        @(posedge clk);
        #2;
        fwd_ra = 5'd3;
        #1;
        check("fwd_hit", 32'(fwd_hit), 32'd1);
        check("fwd_data", fwd_data, 32'h55);
        fwd_ra = 5'd0;
        #1;
        check("fwd_hit_r0", 32'(fwd_hit), 32'd0);
`endif
        idle(2);

        // Slow result to r0 is consumed silently.
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h77);
        idle(2);

        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)), $urandom);
        idle(10);

        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
